// File: rtl/signed_bcd_decoder_pkg.sv
// Shared definitions for the signed binary to BCD decoder.
package signed_bcd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    // Digits at or above this value get +3 before each shift (double dabble).
    localparam logic [3:0] BCD_ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/signed_bcd_decoder_digit_adjust.sv
// One BCD digit correction step of the shift-add-3 algorithm.
module bcd_digit_adjust
    import signed_bcd_decoder_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Add 3 when the digit would overflow past 9 after the next shift.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/signed_bcd_decoder.sv
// Signed two's-complement to sign + magnitude + packed BCD converter.
module signed_bcd_decoder
    import signed_bcd_decoder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_sign,
    output logic [WIDTH-1:0]      out_mag,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   raw_q, raw_d;
    logic               load_q, load_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               out_sign_q, out_sign_d;
    logic [WIDTH-1:0]   out_mag_q, out_mag_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [WIDTH-1:0]   mag_abs;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // Magnitude of the captured word and the next shift-add-3 BCD value.
    always_comb begin
        mag_abs     = raw_q[WIDTH-1] ? (~raw_q + WIDTH'(1)) : raw_q;
        bcd_shifted = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
    end

    // The capture edge only registers the raw word; the first CONVERT cycle
    // negates and loads it, then WIDTH shift cycles follow, so the result
    // lands WIDTH+1 edges after the handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raw_d      = raw_q;
        load_d     = load_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        out_sign_d = out_sign_q;
        out_mag_d  = out_mag_q;
        out_bcd_d  = out_bcd_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    raw_d   = in_data;
                    load_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (load_q) begin
                    load_d  = 1'b0;
                    sign_d  = raw_q[WIDTH-1];
                    mag_d   = mag_abs;
                    shift_d = mag_abs;
                    bcd_d   = '0;
                end else begin
                    bcd_d   = bcd_shifted;
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d      = '0;
                        out_sign_d = sign_q;
                        out_mag_d  = mag_q;
                        out_bcd_d  = bcd_shifted;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            raw_q      <= '0;
            load_q     <= 1'b0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            out_sign_q <= 1'b0;
            out_mag_q  <= '0;
            out_bcd_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raw_q      <= raw_d;
            load_q     <= load_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            out_sign_q <= out_sign_d;
            out_mag_q  <= out_mag_d;
            out_bcd_q  <= out_bcd_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sign  = out_sign_q;
    assign out_mag   = out_mag_q;
    assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_signed_bcd_decoder.sv
// Randomised self-checking bench for signed_bcd_decoder.
module tb_signed_bcd_decoder;

    localparam int W = 8;
    localparam int D = 3;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic           out_sign;
    logic [W-1:0]   out_mag;
    logic [4*D-1:0] out_bcd;
    logic           out_valid;
    logic           out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    signed_bcd_decoder #(
        .WIDTH  (W),
        .DIGITS (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute safety net against a hung run.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: decimal arithmetic on the signed value.
    task automatic ref_model(input logic [W-1:0] v, output logic s,
                             output logic [W-1:0] m, output logic [4*D-1:0] b);
        int val;
        int mg;
        int t;
        val = $signed(v);
        s   = (val < 0);
        mg  = (val < 0) ? -val : val;
        m   = W'(mg);
        b   = '0;
        t   = mg;
        for (int d = 0; d < D; d++) begin
            b[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_one(input logic [W-1:0] v, input int stall, input bit fixed_junk);
        logic           es;
        logic [W-1:0]   em;
        logic [4*D-1:0] eb;
        int             lat;
        bit             busy_ok;
        bit             hold_ok;
        ref_model(v, es, em, eb);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat <= 30) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
            in_valid  = fixed_junk ? 1'b1 : 1'($urandom_range(0, 1));
            in_data   = fixed_junk ? W'(8'h33) : W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        check("busy_in_ready", busy_ok, 1);
        check("sign", out_sign, es);
        check("mag", out_mag, em);
        check("bcd", out_bcd, eb);
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready || out_sign !== es || out_mag !== em || out_bcd !== eb)
                hold_ok = 1'b0;
        end
        check("hold_stable", hold_ok, 1);
        out_ready = 1'b1;
        in_valid  = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        check("consumed_valid", out_valid, 0);
        check("idle_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bit quiet_ok;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sign", out_sign, 0);
        check("rst_mag", out_mag, 0);
        check("rst_bcd", out_bcd, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
        @(negedge clk);

        run_one(8'h05, 2, 1'b0);
        run_one(8'hFB, 1, 1'b0);
        run_one(8'h80, 0, 1'b0);
        run_one(8'h7F, 5, 1'b0);
        run_one(8'h00, 1, 1'b0);
        run_one(8'h9C, 3, 1'b1);

        // Abort a conversion by reset in its fourth cycle.
        out_ready = 1'b0;
        in_data   = 8'h64;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_sign", out_sign, 0);
        check("abort_mag", out_mag, 0);
        check("abort_bcd", out_bcd, 0);
        check("abort_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) quiet_ok = 1'b0;
        end
        check("abort_quiet", quiet_ok, 1);
        run_one(8'hFF, 1, 1'b0);

        for (int v = 0; v < 256; v++) begin
            run_one(W'(v), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
